serial_add_unit: RTL
====================

SERIAL_ADD_UNIT -- requirements
Module: serial_add_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range is 2 to 32.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request a new operation; sampled only in IDLE.
REQ-005 a  input  WIDTH  minuend/augend; captured on the edge that accepts start.
REQ-006 b  input  WIDTH  subtrahend/addend; captured on the edge that accepts start.
REQ-007 cin  input  1  carry-in (add) or borrow-in (sub); captured on the edge that accepts start.
REQ-008 sub  input  1  operation select, 1 = a-b-cin; present only when SERIAL_SUB_EN is defined; captured on the edge that accepts start.
REQ-009 sum  output  WIDTH  result word; registered.
REQ-010 cout  output  1  final carry-out (add) or borrow-out (sub); registered.
REQ-011 busy  output  1  high while in SHIFT.
REQ-012 done  output  1  one-cycle pulse; marks sum/cout valid.

Function
REQ-013 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-014 In IDLE with start=1, the block SHALL latch a, b, cin (and sub), clear the bit counter, and move to SHIFT on that edge.
REQ-015 In SHIFT, each edge SHALL process one bit LSB-first: sum bit = a[i]^b[i]^c, next carry = majority(a[i],b[i],c) (add) or borrow = (~a[i]&b[i]) | (~(a[i]^b[i])&c) (sub).
REQ-016 The block SHALL shift result bits into sum MSB-end-first so that sum[i] holds bit i after WIDTH shifts.
REQ-017 After the edge that processes bit WIDTH-1, the block SHALL be in DONE with cout = final carry/borrow.
REQ-018 Latency: done SHALL be high in the cycle after exactly WIDTH edges following the start-accept edge.
REQ-019 busy SHALL be high for exactly WIDTH cycles per operation.
REQ-020 done SHALL be high for exactly one cycle, in DONE; DONE SHALL return to IDLE on the next edge.
REQ-021 start SHALL be ignored in SHIFT and DONE, with no queuing; operands present at those times SHALL be discarded.
REQ-022 sum and cout SHALL hold their last values in IDLE until the next start is accepted.
REQ-023 Between acceptance and done, sum SHALL be treated as intermediate and is not valid.
REQ-024 Changes on a, b, cin or sub after the accept edge SHALL have no effect on the operation in flight.
REQ-025 Overflow SHALL appear only on cout; arithmetic is modulo 2^WIDTH.

Reset
REQ-026 rst=1 at an edge SHALL force IDLE and set sum=0, cout=0, busy=0, done=0, and clear the counter and carry.
REQ-027 rst SHALL take priority over start and over any in-flight operation; a reset mid-SHIFT aborts without a done pulse.
REQ-028 A start sampled on the same edge as rst=1 SHALL be ignored.

Configuration
REQ-029 With macro SERIAL_SUB_EN defined, the block SHALL include port sub and the borrow datapath of REQ-015.
REQ-030 Without SERIAL_SUB_EN, port sub SHALL be absent, and the block SHALL perform addition only with cin as carry-in.

Verification (WIDTH=8)
REQ-031 Add: a=8'h0F, b=8'h01, cin=0, start pulse -> busy high 8 cycles, then done=1 with sum=8'h10, cout=0.
REQ-032 Add wrap: a=8'hFF, b=8'h01, cin=1 -> sum=8'h01, cout=1; sum/cout held in IDLE after done.
REQ-033 Sub (SERIAL_SUB_EN): a=8'h05, b=8'h07, cin=0, sub=1 -> sum=8'hFE, cout=1; a=8'h09, b=8'h04, cin=1 -> sum=8'h04, cout=0.
REQ-034 start pulsed again in cycles 3 and 8 of SHIFT and in DONE with different operands -> ignored; the first result is unchanged and only one done pulse occurs.
REQ-035 rst asserted in cycle 4 of SHIFT -> next cycle busy=0, done=0, sum=0, cout=0; no done follows; a new start then completes normally.
REQ-036 Back-to-back: start held high continuously -> operations accepted every WIDTH+2 cycles, each with a correct result and a single done pulse.

Source files
------------

// File: rtl/serial_add_unit.sv
// serial_add_unit: bit-serial adder (optionally add/subtract), one result bit per clock, LSB first.
// Latency: done pulses WIDTH+1 cycles after the start-accept edge; busy is high for WIDTH cycles.
// Backpressure: none; start is only honoured in IDLE, and requests in SHIFT/DONE are dropped.
//
// Optional feature macro: SERIAL_SUB_EN adds port sub and the borrow datapath (a - b - cin).
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   start           operation request, sampled only in IDLE
//   a, b, cin       operands and carry/borrow-in, captured on the accept edge
//   sub             1 = subtract (only with SERIAL_SUB_EN)
//   sum, cout       registered result word and final carry/borrow-out
//   busy, done      busy while shifting; done is a one-cycle valid pulse
module serial_add_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic             s_bit;
  logic             c_next;
  logic             last_bit;

  // Operand registers shift right each step, so bit 0 is always the bit in flight.
  assign s_bit    = a_q[0] ^ b_q[0] ^ c_q;
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

`ifdef SERIAL_SUB_EN
  logic sub_q, sub_d;

  always_comb begin
    if (sub_q) begin
      c_next = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & c_q);
    end else begin
      c_next = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
    end
  end
`else
  assign c_next = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SERIAL_SUB_EN
    sub_d   = sub_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          c_d     = cin;
          cnt_d   = '0;
`ifdef SERIAL_SUB_EN
          sub_d   = sub;
`endif
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // New bit enters at the MSB; after WIDTH shifts bit i sits at sum[i].
        sum_d = {s_bit, sum_q[WIDTH-1:1]};
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        c_d   = c_next;
        cnt_d = cnt_q + 1'b1;
        if (last_bit) begin
          cout_d  = c_next;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SERIAL_SUB_EN
      sub_q   <= sub_d;
`endif
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);

endmodule
